// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared opcodes, FSM encoding and requester count for the ALU arbiter
package alu_ctrl_pkg;

  localparam int NREQ = 2;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_RSUB  = 3'b010;
  localparam logic [2:0] OP_PASSA = 3'b011;
  localparam logic [2:0] OP_PASSB = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_OR    = 3'b110;
  localparam logic [2:0] OP_XOR   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ALU.sv
// rtl/ALU.sv - combinational ALU; carry and overflow always come from A+B
module ALU #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] out,
  output logic         cout,
  output logic         overflow,
  output logic         zero
);
  import alu_ctrl_pkg::*;

  logic [W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    out = '0;
    case (op)
      OP_ADD:   out = sum[W-1:0];
      OP_SUB:   out = a - b;
      OP_RSUB:  out = b - a;
      OP_PASSA: out = a;
      OP_PASSB: out = b;
      OP_AND:   out = a & b;
      OP_OR:    out = a | b;
      OP_XOR:   out = a ^ b;
    endcase
  end

  assign cout     = sum[W];
  assign overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
  assign zero     = (out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sequencing two requesters onto one shared ALU
module alu_arbiter #(
  parameter int NREQ = alu_ctrl_pkg::NREQ,
  parameter int W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [W-1:0]    req_a0,
  input  logic [W-1:0]    req_b0,
  input  logic [2:0]      req_op0,
  input  logic [W-1:0]    req_a1,
  input  logic [W-1:0]    req_b1,
  input  logic [2:0]      req_op1,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [W-1:0]    rsp_out,
  output logic            rsp_cout,
  output logic            rsp_ovf,
  output logic            rsp_zero,
  output logic            busy
);
  import alu_ctrl_pkg::*;

  state_t      state;
  logic        last;
  logic        id_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [2:0]  op_q;

  logic        grant_valid;
  logic        grant_id;

  logic [W-1:0] alu_out;
  logic        alu_cout;
  logic        alu_ovf;
  logic        alu_zero;

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req_valid[0] && req_valid[1]) begin
      grant_valid = 1'b1;
      grant_id    = ~last;
    end else if (req_valid[0]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req_valid[1]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_valid && !rst)
      req_ready[grant_id] = 1'b1;
  end

  assign busy = (state != IDLE);

  ALU #(.W(W)) u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .out      (alu_out),
    .cout     (alu_cout),
    .overflow (alu_ovf),
    .zero     (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      id_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_out   <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            a_q   <= grant_id ? req_a1 : req_a0;
            b_q   <= grant_id ? req_b1 : req_b0;
            op_q  <= grant_id ? req_op1 : req_op0;
            id_q  <= grant_id;
            last  <= grant_id;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_out   <= alu_out;
          rsp_cout  <= alu_cout;
          rsp_ovf   <= alu_ovf;
          rsp_zero  <= alu_zero;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed bench for alu_arbiter against a transaction model
module tb_alu_arbiter;

  typedef struct packed {
    logic [3:0] out;
    logic       cout;
    logic       ovf;
    logic       zero;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [3:0] req_a0 = 4'd0, req_b0 = 4'd0, req_a1 = 4'd0, req_b1 = 4'd0;
  logic [2:0] req_op0 = 3'd0, req_op1 = 3'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_id;
  logic [3:0] rsp_out;
  logic       rsp_cout, rsp_ovf, rsp_zero, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Transaction-level model: an accepted job, a visible response, and the tie pointer.
  bit   m_pend = 0, m_shown = 0, m_last = 1, m_pid = 0, m_id = 0;
  res_t m_pres = '0, m_rsp = '0;
  int   acc_id[$];
  int   acc_cyc[$];

  bit         c_idle, c_g;
  logic [1:0] c_exp_ready;

  logic [3:0] sweep_exp [8] = '{4'd6, 4'd2, 4'd14, 4'd12, 4'd10, 4'd8, 4'd14, 4'd6};

  alu_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_op0   (req_op0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_op1   (req_op1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t ref_alu(input int a, input int b, input int op);
    int   r, sa, sb;
    res_t x;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = b - a;
      3:       r = a;
      4:       r = b;
      5:       r = a & b;
      6:       r = a | b;
      default: r = a ^ b;
    endcase
    r  = ((r % 16) + 16) % 16;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    x.out  = r[3:0];
    x.cout = (a + b) > 15;
    x.ovf  = (sa + sb > 7) || (sa + sb < -8);
    x.zero = (r == 0);
    return x;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      c_idle = !m_pend && !m_shown;
      c_g    = (req_valid == 2'b11) ? !m_last : req_valid[1];
      c_exp_ready = 2'b00;
      if (c_idle && req_valid != 2'b00 && !rst)
        c_exp_ready = c_g ? 2'b10 : 2'b01;
      chk("req_ready", req_ready, c_exp_ready);
      chk("busy", busy, !c_idle);
      chk("rsp_valid", rsp_valid, m_shown);
      if (m_shown) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_out", rsp_out, m_rsp.out);
        chk("rsp_cout", rsp_cout, m_rsp.cout);
        chk("rsp_ovf", rsp_ovf, m_rsp.ovf);
        chk("rsp_zero", rsp_zero, m_rsp.zero);
      end
      if ((req_valid & req_ready) != 2'b00 && !rst) begin
        acc_id.push_back(req_ready[1] ? 1 : 0);
        acc_cyc.push_back(cyc);
      end
      if (rst) begin
        m_pend = 0; m_shown = 0; m_last = 1; m_id = 0; m_rsp = '0;
      end else if (c_idle && req_valid != 2'b00) begin
        m_pend = 1;
        m_pid  = c_g;
        m_last = c_g;
        m_pres = c_g ? ref_alu(req_a1, req_b1, req_op1) : ref_alu(req_a0, req_b0, req_op0);
      end else if (m_pend) begin
        m_pend = 0; m_shown = 1; m_rsp = m_pres; m_id = m_pid;
      end else if (m_shown && rsp_ready) begin
        m_shown = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    bit got = 0;
    if (id) begin req_a1 = a; req_b1 = b; req_op1 = op; end
    else    begin req_a0 = a; req_b0 = b; req_op0 = op; end
    req_valid[id] = 1'b1;
    for (int i = 0; i < 12 && !got; i++) begin
      #1;
      got = req_ready[id];
      tick();
    end
    req_valid[id] = 1'b0;
    chk("issue_accept", got, 1);
  endtask

  task automatic expect_rsp(input string tag, input bit id, input logic [3:0] out,
                            input bit c, input bit o, input bit z);
    int n = 0;
    while (!rsp_valid && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, rsp_valid, 1);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_out"}, rsp_out, out);
    chk({tag, "_cout"}, rsp_cout, c);
    chk({tag, "_ovf"}, rsp_ovf, o);
    chk({tag, "_zero"}, rsp_zero, z);
  endtask

  initial begin
    logic [3:0] hold_out;
    bit         hold_id;
    bit         got;

    // Hand-computed values that pin the reference ALU.
    chk("model_add", ref_alu(3, 5, 0), {4'd8, 1'b0, 1'b1, 1'b0});
    chk("model_zero", ref_alu(5, 5, 1), {4'd0, 1'b0, 1'b1, 1'b1});
    for (int op = 0; op < 8; op++)
      chk("model_sweep", ref_alu(12, 10, op), {sweep_exp[op], 1'b1, 1'b1, 1'b0});

    tick();
    chk_en = 1;
    tick();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_out", {rsp_id, rsp_out, rsp_cout, rsp_ovf, rsp_zero}, 0);
    rst = 1'b0;
    tick();

    // Single request with 2-cycle latency.
    rsp_ready = 1'b1;
    issue(0, 4'd3, 4'd5, 3'b000);
    chk("t1_busy_exec", busy, 1);
    chk("t1_no_rsp_yet", rsp_valid, 0);
    tick();
    chk("t1_rsp_latency", rsp_valid, 1);
    chk("t1_busy_resp", busy, 1);
    expect_rsp("t1", 0, 4'd8, 0, 1, 0);

    issue(1, 4'd5, 4'd5, 3'b001);
    expect_rsp("t2", 1, 4'd0, 0, 1, 1);
    tick(); tick();

    // Both requesters hold valid: grants alternate, 3 cycles apart.
    acc_id.delete(); acc_cyc.delete();
    req_a0 = 4'd1; req_b0 = 4'd2; req_op0 = 3'b000;
    req_a1 = 4'd7; req_b1 = 4'd9; req_op1 = 3'b111;
    req_valid = 2'b11;
    repeat (13) tick();
    req_valid = 2'b00;
    repeat (4) tick();
    chk("rr_count", acc_id.size() >= 4, 1);
    for (int i = 0; i < 4; i++) chk("rr_id", acc_id[i], i % 2);
    for (int i = 1; i < 4; i++) chk("rr_spacing", acc_cyc[i] - acc_cyc[i-1], 3);

    // Backpressure: response held, no new grant.
    rsp_ready = 1'b0;
    issue(0, 4'd9, 4'd7, 3'b101);
    expect_rsp("bp", 0, 4'd1, 1, 0, 0);
    hold_out = rsp_out;
    hold_id  = rsp_id;
    req_a1 = 4'd2; req_b1 = 4'd2; req_op1 = 3'b000;
    req_valid[1] = 1'b1;
    repeat (5) begin
      tick();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_out", rsp_out, hold_out);
      chk("bp_hold_id", rsp_id, hold_id);
      chk("bp_no_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_done", rsp_valid, 0);
    chk("bp_next_ready", req_ready, 2'b10);
    req_valid = 2'b00;
    repeat (4) tick();

    // Reset while a response is pending.
    rsp_ready = 1'b0;
    issue(1, 4'd2, 4'd3, 3'b000);
    expect_rsp("rr_pre", 1, 4'd5, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_regs", {rsp_id, rsp_out, rsp_cout, rsp_ovf, rsp_zero}, 0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_a0 = 4'd1; req_b0 = 4'd2; req_op0 = 3'b000;
    req_a1 = 4'd4; req_b1 = 4'd4; req_op1 = 3'b000;
    req_valid = 2'b11;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      #1;
      got = (req_ready != 2'b00);
      tick();
    end
    req_valid = 2'b00;
    expect_rsp("tie_after_rst", 0, 4'd3, 0, 0, 0);
    tick(); tick();

    // Opcode sweep.
    for (int op = 0; op < 8; op++) begin
      issue(0, 4'b1100, 4'b1010, op[2:0]);
      expect_rsp("sweep", 0, sweep_exp[op], 1, 1, 0);
    end
    tick(); tick();

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 79) == 0);
      req_valid = 2'($urandom);
      req_a0    = 4'($urandom);
      req_b0    = 4'($urandom);
      req_op0   = 3'($urandom);
      req_a1    = 4'($urandom);
      req_b1    = 4'($urandom);
      req_op1   = 3'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one 4-bit ALU datapath (module `ALU`) between two independent requesters. Each requester presents operands and an opcode on a valid/ready channel. The block grants one request at a time, registers its operands into the ALU, and captures the result and flags. It then returns them on a single shared response channel tagged with the requester ID. It sits between the instruction-issue logic and the ALU, and is the only block that drives the ALU inputs.

## Interface

Parameters:
- `NREQ`, 2: number of requesters. Fixed at 2; the package constant must match.
- `W`, 4: datapath width. Fixed by the ALU.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  2  per-requester request valid.
- `req_ready`  out  2  per-requester accept. The request is taken on an edge where valid and ready are both high.
- `req_a0`, `req_b0`  in  4 each  operands, requester 0.
- `req_op0`  in  3  opcode, requester 0.
- `req_a1`, `req_b1`  in  4 each  operands, requester 1.
- `req_op1`  in  3  opcode, requester 1.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  requester index that owns the response.
- `rsp_out`  out  4  ALU result.
- `rsp_cout`  out  1  carry flag.
- `rsp_ovf`  out  1  overflow flag.
- `rsp_zero`  out  1  zero flag.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation

- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from `req_valid` and the round-robin pointer `last`.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester other than `last` is granted.
  - `req_ready` is high only for the granted index, and only in IDLE.
  - On the accept edge:
    - latch a, b and op into operand registers;
    - latch the granted index into `id_q`;
    - set `last` to the granted index;
    - go to EXEC.
- EXEC:
  - The ALU evaluates the registered operands combinationally.
  - On the edge:
    - capture out, cout, overflow and zero into the response registers;
    - set `rsp_valid`;
    - go to RESP.
- RESP:
  - Hold all `rsp_*` outputs stable while `rsp_ready` is low.
  - On an edge where `rsp_valid` and `rsp_ready` are both high, clear `rsp_valid` and go to IDLE.
- Opcodes pass through to the ALU unchanged: 000 add, 001 A-B, 010 B-A, 011 A, 100 B, 101 AND, 110 OR, 111 XOR.
  - All 8 opcodes are legal.
  - Results are 4-bit modulo-16.
- Flags are the ALU's flags, captured verbatim.
  - cout and overflow are always derived from A+B, whatever the opcode.
  - zero reflects the opcode's result.
- Only one operation is in flight at a time. No request is accepted outside IDLE.
- A requester that drops `req_valid` before acceptance loses its turn. `last` is not updated.
- Reset values:
  - state IDLE;
  - `last`=1, so requester 0 wins the first tie;
  - `rsp_valid`=0, `rsp_id`=0, `rsp_out`=0, `rsp_cout`=0, `rsp_ovf`=0, `rsp_zero`=0;
  - `busy`=0;
  - `req_ready`=0 during reset.
- Reset asserted mid-operation (EXEC or RESP):
  - the transaction is discarded, with no response;
  - all outputs take their reset values on that edge.

## Timing

- Accept on edge N, `rsp_valid` high after edge N+1. Latency is 2 cycles from the accept edge.
- Response handshake on edge M; `req_ready` can be high in cycle M+1 (IDLE).
- Minimum initiation interval is 3 cycles per operation (IDLE, EXEC, RESP with `rsp_ready` held high).
- Operand inputs are sampled only on the accept edge. Changes afterwards have no effect.
- `req_ready` depends combinationally on `req_valid`. `req_valid` must not depend on `req_ready`.
- `rsp_*` outputs are registered, with no combinational path from `rsp_ready`.

## Structure

- Shared package `alu_ctrl_pkg`:
  - opcode localparams `OP_ADD` … `OP_XOR` (3'b000–3'b111);
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - `NREQ`=2.
- One sub-module instance: the existing `ALU`, driven from the operand registers.
- All control logic stays in `alu_arbiter`: FSM, round-robin pointer, operand and response registers.

## Test plan

- Single request, requester 0: a=3, b=5, op=000, `rsp_ready`=1.
  - `rsp_valid` is high 2 cycles after accept.
  - Response: id=0, out=8, cout=0, ovf=1, zero=0.
  - `busy` is high in EXEC and RESP.
- Zero result, requester 1: a=5, b=5, op=001.
  - Response: id=1, out=0, zero=1, cout=0, ovf=1 (flags taken from A+B=1010).
- Both requesters valid continuously, `rsp_ready`=1:
  - grants alternate 0,1,0,1 over 4 transactions;
  - each `req_ready` pulse lasts exactly 1 cycle;
  - accepts are 3 cycles apart.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid`.
  - out, id and flags are held stable.
  - `req_ready` stays 0.
  - The transaction completes on the first cycle with `rsp_ready`=1.
- Reset in RESP: assert `rst` while `rsp_valid`=1.
  - Next cycle: `rsp_valid`=0 and `busy`=0.
  - A following tie is granted to requester 0.
- Opcode sweep: a=4'b1100, b=4'b1010, ops 000–111.
  - out = 6, 2, 14, 12, 10, 8, 14, 6 respectively.
  - cout=1 and ovf=1 for all ops.
